conv_result_reader: RTL and testbench

CONV_RESULT_READER -- requirements
Module: conv_result_reader

---
 rtl/conv_result_reader.sv | 141 ++++++++++++++
 tb/tb_conv_result_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_reader.sv
// conv_result_reader: streams the convolution result RAM out as a
// valid/ready word stream, one word per FETCH -> LOAD -> SEND round.
// Optional clear-after-read is built when CONV_RD_CLEAR_EN is defined.
// In that build each word's address is written back (data tied to 0
// by the integrator) so the RAM is all-zero for the next convolution.
module conv_result_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   sizeX,
  input  logic [ADDR_WIDTH-1:0]   sizeY,
  output logic [ADDR_WIDTH:0]     memZ_addr,
  input  logic [2*DATA_WIDTH-1:0] memZ_data,
  output logic                    memZ_clr_en,
  output logic [ADDR_WIDTH:0]     memZ_clr_addr,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     idx_q;
  logic [ADDR_WIDTH:0]     n_q;
  logic [ADDR_WIDTH:0]     addr_q;
  logic [2*DATA_WIDTH-1:0] dout_q;
  logic                    valid_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    done_q;

  // word count of the full convolution; only meaningful when both sizes are non-zero
  logic [ADDR_WIDTH:0] n_d;
  logic [ADDR_WIDTH:0] last_idx;
  logic                is_last;

  assign n_d      = {1'b0, sizeX} + {1'b0, sizeY} - ONE;
  assign last_idx = n_q - ONE;
  assign is_last  = (idx_q == last_idx);

`ifdef CONV_RD_CLEAR_EN
  logic                clr_en_q;
  logic [ADDR_WIDTH:0] clr_addr_q;
  assign memZ_clr_en   = clr_en_q;
  assign memZ_clr_addr = clr_addr_q;
`else
  assign memZ_clr_en   = 1'b0;
  assign memZ_clr_addr = '0;
`endif

  assign memZ_addr  = addr_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // readout FSM; every output is registered so it changes only on clk
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CONV_RD_CLEAR_EN
      clr_en_q   <= 1'b0;
      clr_addr_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q    <= n_d;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (sizeX == '0 || sizeY == '0) begin
              // empty result: skip straight to the completion pulse
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              addr_q  <= '0;
            end
          end
        end
        FETCH: begin
          // address has been on memZ_addr this cycle; RAM data lands during LOAD
          state_q    <= LOAD;
`ifdef CONV_RD_CLEAR_EN
          clr_en_q   <= 1'b1;
          clr_addr_q <= idx_q;
`endif
        end
        LOAD: begin
          dout_q   <= memZ_data;
          valid_q  <= 1'b1;
          last_q   <= is_last;
          state_q  <= SEND;
`ifdef CONV_RD_CLEAR_EN
          clr_en_q <= 1'b0;
`endif
        end
        SEND: begin
          if (dout_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (is_last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + ONE;
              addr_q  <= idx_q + ONE;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// Scoreboard bench for conv_result_reader: stimulus pushes expected words,
// a negedge monitor pops and compares on every dout transfer.
module tb_conv_result_reader;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   sizeX = '0;
  logic [AW-1:0]   sizeY = '0;
  logic [AW:0]     memZ_addr;
  logic [2*DW-1:0] memZ_data = '0;
  logic            memZ_clr_en;
  logic [AW:0]     memZ_clr_addr;
  logic [2*DW-1:0] dout;
  logic            dout_valid;
  logic            dout_ready = 1'b1;
  logic            dout_last;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp_q[$];
  int          clr_log[$];
  int          done_cnt = 0;
  int          max_addr = 0;
  bit          clr_seen = 1'b0;
  bit          rdy_mode = 1'b0;
  bit          mem_init = 1'b0;
  logic [63:0] cleared = '0;

  conv_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .sizeX(sizeX), .sizeY(sizeY),
    .memZ_addr(memZ_addr), .memZ_data(memZ_data), .memZ_clr_en(memZ_clr_en),
    .memZ_clr_addr(memZ_clr_addr), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // result RAM: word i holds i+100 until cleared by a clear-after-read write
  always @(posedge clk) begin
    if (mem_init) cleared <= '0;
    else if (memZ_clr_en) cleared[memZ_clr_addr] <= 1'b1;
    memZ_data <= cleared[memZ_addr] ? '0 : 64'(memZ_addr) + 64'd100;
  end

  // ready driver: always 1, or high one cycle in three when stalling
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    dout_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
    cyc++;
  end

  // monitor
  logic            prev_stall = 1'b0;
  logic [2*DW-1:0] prev_dout = '0;
  logic            prev_last = 1'b0;
  logic            prev_done = 1'b0;
  logic            prev_clr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("dout", dout, e.data);
        chk("dout_last", 64'(dout_last), 64'(e.last));
      end
    end
    if (dout_last) chk("last_without_valid", 64'(dout_valid), 1);
    if (prev_stall) begin
      chk("stall_valid", 64'(dout_valid), 1);
      chk("stall_dout", dout, prev_dout);
      chk("stall_last", 64'(dout_last), 64'(prev_last));
    end
    prev_stall = dout_valid && !dout_ready && rstn;
    prev_dout  = dout;
    prev_last  = dout_last;
    if (done) begin
      chk("done_width", 64'(prev_done), 0);
      done_cnt++;
    end
    prev_done = done;
    if (int'(memZ_addr) > max_addr) max_addr = int'(memZ_addr);
`ifdef CONV_RD_CLEAR_EN
    if (memZ_clr_en) begin
      chk("clr_width", 64'(prev_clr), 0);
      clr_log.push_back(int'(memZ_clr_addr));
    end
`else
    if (memZ_clr_en || memZ_clr_addr != '0) clr_seen = 1'b1;
`endif
    prev_clr = memZ_clr_en;
  end

  task automatic push_exp(input int n, input bit zero);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = zero ? '0 : 64'(i + 100);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic init_mem();
    @(posedge clk); #1 mem_init = 1'b1;
    @(posedge clk); #1 mem_init = 1'b0;
  endtask

  // start is sampled at the first posedge after this is entered
  task automatic start_pulse(input int sx, input int sy);
    @(posedge clk); #1;
    sizeX = AW'(sx);
    sizeY = AW'(sy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int c = 0; c < 600 && done_cnt == d0; c++) @(negedge clk);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 0);
    chk({tag, "_words_left"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    int d0;
    int rises;
    bit pv;

    // reset state
    #12;
    chk("rst_valid", 64'(dout_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_addr", 64'(memZ_addr), 0);
    chk("rst_dout", dout, 0);
    @(negedge clk); rstn = 1'b1;
    init_mem();

    // 5x10, ready high: latency and 14-word stream
    push_exp(14, 1'b0);
    d0 = done_cnt;
    start_pulse(5, 10);
    @(negedge clk);
    chk("lat_busy_e0", 64'(busy), 1);
    chk("lat_valid_e0", 64'(dout_valid), 0);
    @(negedge clk);
    chk("lat_valid_e1", 64'(dout_valid), 0);
    chk("lat_addr_e1", 64'(memZ_addr), 0);
    @(negedge clk);
    chk("lat_valid_e2", 64'(dout_valid), 1);
    wait_done(d0, "t1");

    // same sizes, ready 1-of-3, with ignored start and size changes mid-run
    init_mem();
    rdy_mode = 1'b1;
    push_exp(14, 1'b0);
    d0 = done_cnt;
    start_pulse(5, 10);
    repeat (10) @(negedge clk);
    start = 1'b1; sizeX = 5'd1; sizeY = 5'd1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(d0, "t2");
    rdy_mode = 1'b0;

    // sizeX = 0: immediate done, no words
    d0 = done_cnt;
    start_pulse(0, 7);
    @(negedge clk);
    chk("z_done_e0", 64'(done), 1);
    chk("z_busy_e0", 64'(busy), 1);
    @(negedge clk);
    chk("z_done_e1", 64'(done), 0);
    chk("z_busy_e1", 64'(busy), 0);
    chk("z_done_count", 64'(done_cnt - d0), 1);

    // 31x31: 61 words, addresses 0..60
    init_mem();
    max_addr = 0;
    push_exp(61, 1'b0);
    d0 = done_cnt;
    start_pulse(31, 31);
    wait_done(d0, "t4");
    chk("max_addr", 64'(max_addr), 60);
    chk("hold_addr", 64'(memZ_addr), 60);

    // reset during the third SEND, then restart from address 0
    init_mem();
    push_exp(14, 1'b0);
    d0 = done_cnt;
    start_pulse(5, 10);
    rises = 0; pv = 1'b0;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge clk);
      if (dout_valid && !pv) rises++;
      pv = dout_valid;
    end
    chk("r_third_send", 64'(rises), 3);
    #1 rstn = 1'b0;
    #1;
    chk("r_valid", 64'(dout_valid), 0);
    chk("r_busy", 64'(busy), 0);
    chk("r_done", 64'(done), 0);
    chk("r_last", 64'(dout_last), 0);
    chk("r_dout", dout, 0);
    chk("r_addr", 64'(memZ_addr), 0);
    chk("r_clr_en", 64'(memZ_clr_en), 0);
    chk("r_clr_addr", 64'(memZ_clr_addr), 0);
    exp_q.delete();
    @(negedge clk); #1 rstn = 1'b1;
    chk("r_no_done", 64'(done_cnt - d0), 0);
    init_mem();
    push_exp(3, 1'b0);
    d0 = done_cnt;
    start_pulse(2, 2);
    wait_done(d0, "t5");

`ifdef CONV_RD_CLEAR_EN
    // clear-after-read: second pass reads zeros
    init_mem();
    clr_log.delete();
    push_exp(3, 1'b0);
    d0 = done_cnt;
    start_pulse(2, 2);
    wait_done(d0, "c1");
    chk("clr_count", 64'(clr_log.size()), 3);
    for (int i = 0; i < 3 && i < clr_log.size(); i++) chk("clr_addr", 64'(clr_log[i]), 64'(i));
    push_exp(3, 1'b1);
    d0 = done_cnt;
    start_pulse(2, 2);
    wait_done(d0, "c2");
`else
    chk("clr_constant_zero", 64'(clr_seen), 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
